// File: rtl/osc_rst_pkg.sv
// Shared types, timing defaults and helpers for the oscillator reset sequencer.
package osc_rst_pkg;

    // Sequencer state encoding, also exported on the STATE debug port.
    typedef enum logic [2:0] {
        RST_HOLD    = 3'd0,
        WAIT_LOCK   = 3'd1,
        LOCK_STABLE = 3'd2,
        MSS_DELAY   = 3'd3,
        WAIT_MSS    = 3'd4,
        RUN         = 3'd5,
        ERROR       = 3'd6
    } osc_rst_state_e;

    // Default timing at the 50 MHz RC-oscillator clock.
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_MSS_RELEASE_DELAY  = 256;
    localparam int DEF_MSS_READY_TIMEOUT  = 65535;
    localparam int DEF_SYNC_STAGES        = 2;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Largest of three values, used to size the shared counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/osc_rst_sync.sv
// Multi-stage flop chain for bringing an asynchronous level into the CLK domain.
module osc_rst_sync
    import osc_rst_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the input through the chain; all stages clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/osc_reset_sequencer.sv
// Power-up reset sequencer: waits for stable CCC lock, releases the MSS,
// waits for MSS ready, then releases the fabric. Re-sequences on lock loss
// or soft-reset request and flags an MSS ready timeout.
module osc_reset_sequencer
    import osc_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int MSS_RELEASE_DELAY  = DEF_MSS_RELEASE_DELAY,
    parameter int MSS_READY_TIMEOUT  = DEF_MSS_READY_TIMEOUT,
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       CCC_LOCK,
    input  logic       MSS_READY,
    input  logic       SOFT_RESET_REQ,
    output logic       MSS_RESET_N,
    output logic       FABRIC_RESET_N,
    output logic       INIT_DONE,
    output logic       TIMEOUT_ERR,
    output logic [2:0] STATE
);

    localparam int CNT_W = clog2(max3(LOCK_STABLE_CYCLES, MSS_RELEASE_DELAY,
                                      MSS_READY_TIMEOUT)) + 1;
    localparam logic [CNT_W-1:0] LOCK_TC    = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_TC   = CNT_W'(MSS_RELEASE_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(MSS_READY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic           rst_rel_s;
    logic           lock_s;
    logic           ready_s;
    osc_rst_state_e state_r;
    osc_rst_state_e state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic           mss_reset_n_r;
    logic           fabric_reset_n_r;
    logic           init_done_r;
    logic           timeout_err_r;

    // Reset release: the FSM leaves RST_HOLD only after RESETN deassertion
    // has been synchronized to CLK.
    osc_rst_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (
        .clk(CLK), .rst_n(RESETN), .d(1'b1), .q(rst_rel_s)
    );

    osc_rst_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk(CLK), .rst_n(RESETN), .d(CCC_LOCK), .q(lock_s)
    );

    osc_rst_sync #(.STAGES(SYNC_STAGES)) u_sync_ready (
        .clk(CLK), .rst_n(RESETN), .d(MSS_READY), .q(ready_s)
    );

    // Next-state selection; soft reset outranks lock loss, which outranks
    // ready, which outranks the timeout terminal count.
    always_comb begin
        state_nxt_s = state_r;
        if (SOFT_RESET_REQ && (state_r != RST_HOLD)) begin
            state_nxt_s = RST_HOLD;
        end else begin
            case (state_r)
                RST_HOLD: begin
                    if (rst_rel_s) state_nxt_s = WAIT_LOCK;
                    else           state_nxt_s = RST_HOLD;
                end
                WAIT_LOCK: begin
                    if (lock_s) state_nxt_s = LOCK_STABLE;
                    else        state_nxt_s = WAIT_LOCK;
                end
                LOCK_STABLE: begin
                    if (!lock_s)               state_nxt_s = WAIT_LOCK;
                    else if (cnt_r == LOCK_TC) state_nxt_s = MSS_DELAY;
                    else                       state_nxt_s = LOCK_STABLE;
                end
                MSS_DELAY: begin
                    if (!lock_s)                state_nxt_s = WAIT_LOCK;
                    else if (cnt_r == DELAY_TC) state_nxt_s = WAIT_MSS;
                    else                        state_nxt_s = MSS_DELAY;
                end
                WAIT_MSS: begin
                    if (!lock_s)                  state_nxt_s = WAIT_LOCK;
                    else if (ready_s)             state_nxt_s = RUN;
                    else if (cnt_r == TIMEOUT_TC) state_nxt_s = ERROR;
                    else                          state_nxt_s = WAIT_MSS;
                end
                RUN: begin
                    if (!lock_s) state_nxt_s = WAIT_LOCK;
                    else         state_nxt_s = RUN;
                end
                ERROR: begin
                    state_nxt_s = ERROR;
                end
                default: begin
                    state_nxt_s = RST_HOLD;
                end
            endcase
        end
    end

    // State, per-state counter and outputs, all decoded from the next state
    // so every output is a flop that changes on the same edge as STATE.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r          <= RST_HOLD;
            cnt_r            <= '0;
            mss_reset_n_r    <= 1'b0;
            fabric_reset_n_r <= 1'b0;
            init_done_r      <= 1'b0;
            timeout_err_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            mss_reset_n_r    <= (state_nxt_s == WAIT_MSS) || (state_nxt_s == RUN) ||
                                (state_nxt_s == ERROR);
            fabric_reset_n_r <= (state_nxt_s == RUN);
            init_done_r      <= (state_nxt_s == RUN);
            if (SOFT_RESET_REQ) begin
                timeout_err_r <= 1'b0;
            end else if (state_nxt_s == ERROR) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign MSS_RESET_N    = mss_reset_n_r;
    assign FABRIC_RESET_N = fabric_reset_n_r;
    assign INIT_DONE      = init_done_r;
    assign TIMEOUT_ERR    = timeout_err_r;
    assign STATE          = state_r;

endmodule

// File: tb/tb_osc_reset_sequencer.sv
// Directed self-checking bench for osc_reset_sequencer with short timing
// parameters (lock 16, delay 8, timeout 100, 2 sync stages).
module tb_osc_reset_sequencer;

    logic       CLK;
    logic       RESETN;
    logic       CCC_LOCK;
    logic       MSS_READY;
    logic       SOFT_RESET_REQ;
    logic       MSS_RESET_N;
    logic       FABRIC_RESET_N;
    logic       INIT_DONE;
    logic       TIMEOUT_ERR;
    logic [2:0] STATE;

    int n_checks;
    int n_fail;

    osc_reset_sequencer #(
        .LOCK_STABLE_CYCLES(16),
        .MSS_RELEASE_DELAY (8),
        .MSS_READY_TIMEOUT (100),
        .SYNC_STAGES       (2)
    ) dut (
        .CLK           (CLK),
        .RESETN        (RESETN),
        .CCC_LOCK      (CCC_LOCK),
        .MSS_READY     (MSS_READY),
        .SOFT_RESET_REQ(SOFT_RESET_REQ),
        .MSS_RESET_N   (MSS_RESET_N),
        .FABRIC_RESET_N(FABRIC_RESET_N),
        .INIT_DONE     (INIT_DONE),
        .TIMEOUT_ERR   (TIMEOUT_ERR),
        .STATE         (STATE)
    );

    // 50 MHz clock.
    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (STATE === target) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESETN = 1'b0; CCC_LOCK = 1'b1; MSS_READY = 1'b0; SOFT_RESET_REQ = 1'b0;
        repeat (10) tick();
        n_checks++; if (STATE !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", STATE); end
        n_checks++; if (MSS_RESET_N !== 1'b0) begin n_fail++; $display("FAIL rst_mss: got %b exp 0", MSS_RESET_N); end
        n_checks++; if (FABRIC_RESET_N !== 1'b0) begin n_fail++; $display("FAIL rst_fab: got %b exp 0", FABRIC_RESET_N); end
        n_checks++; if (INIT_DONE !== 1'b0) begin n_fail++; $display("FAIL rst_init: got %b exp 0", INIT_DONE); end
        n_checks++; if (TIMEOUT_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_terr: got %b exp 0", TIMEOUT_ERR); end
        RESETN = 1'b1;
    endtask

    task automatic test_sequence();
        logic [2:0] exp_state;
        for (int k = 1; k <= 28; k++) begin
            tick();
            exp_state = (k <= 2) ? 3'd0 : (k == 3) ? 3'd1 : (k <= 19) ? 3'd2 : (k <= 27) ? 3'd3 : 3'd4;
            n_checks++; if (STATE !== exp_state) begin n_fail++; $display("FAIL seq_state[%0d]: got %0d exp %0d", k, STATE, exp_state); end
            n_checks++; if (MSS_RESET_N !== (k == 28)) begin n_fail++; $display("FAIL seq_mss[%0d]: got %b exp %b", k, MSS_RESET_N, (k == 28)); end
            n_checks++; if (FABRIC_RESET_N !== 1'b0) begin n_fail++; $display("FAIL seq_fab[%0d]: got %b exp 0", k, FABRIC_RESET_N); end
        end
        repeat (19) tick();
        n_checks++; if (STATE !== 3'd4) begin n_fail++; $display("FAIL seq_wait_mss: got %0d exp 4", STATE); end
        MSS_READY = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_checks++; if (STATE !== 3'd4) begin n_fail++; $display("FAIL seq_ready_lat[%0d]: got %0d exp 4", k, STATE); end
            n_checks++; if (INIT_DONE !== 1'b0) begin n_fail++; $display("FAIL seq_init_early[%0d]: got %b exp 0", k, INIT_DONE); end
        end
        tick();
        n_checks++; if (STATE !== 3'd5) begin n_fail++; $display("FAIL seq_run: got %0d exp 5", STATE); end
        n_checks++; if (FABRIC_RESET_N !== 1'b1) begin n_fail++; $display("FAIL seq_run_fab: got %b exp 1", FABRIC_RESET_N); end
        n_checks++; if (INIT_DONE !== 1'b1) begin n_fail++; $display("FAIL seq_run_init: got %b exp 1", INIT_DONE); end
        n_checks++; if (MSS_RESET_N !== 1'b1) begin n_fail++; $display("FAIL seq_run_mss: got %b exp 1", MSS_RESET_N); end
    endtask

    task automatic test_lock_loss_and_glitch();
        bit found;
        CCC_LOCK = 1'b0; MSS_READY = 1'b0;
        tick();
        n_checks++; if (INIT_DONE !== 1'b1) begin n_fail++; $display("FAIL loss_lat1: got %b exp 1", INIT_DONE); end
        tick();
        n_checks++; if (STATE !== 3'd5) begin n_fail++; $display("FAIL loss_lat2: got %0d exp 5", STATE); end
        tick();
        n_checks++; if (STATE !== 3'd1) begin n_fail++; $display("FAIL loss_state: got %0d exp 1", STATE); end
        n_checks++; if ({MSS_RESET_N, FABRIC_RESET_N, INIT_DONE} !== 3'b000) begin n_fail++; $display("FAIL loss_outs: got %b exp 000", {MSS_RESET_N, FABRIC_RESET_N, INIT_DONE}); end
        repeat (3) tick();
        n_checks++; if (STATE !== 3'd1) begin n_fail++; $display("FAIL loss_hold: got %0d exp 1", STATE); end
        CCC_LOCK = 1'b1;
        tick(); tick();
        n_checks++; if (STATE !== 3'd1) begin n_fail++; $display("FAIL relock_lat: got %0d exp 1", STATE); end
        tick();
        n_checks++; if (STATE !== 3'd2) begin n_fail++; $display("FAIL relock_stable: got %0d exp 2", STATE); end
        // Glitch so that lock_s is low while the lock counter reads 10.
        repeat (8) tick();
        CCC_LOCK = 1'b0;
        tick();
        CCC_LOCK = 1'b1;
        n_checks++; if (STATE !== 3'd2) begin n_fail++; $display("FAIL glitch_pre9: got %0d exp 2", STATE); end
        tick();
        n_checks++; if (STATE !== 3'd2) begin n_fail++; $display("FAIL glitch_pre10: got %0d exp 2", STATE); end
        tick();
        n_checks++; if (STATE !== 3'd1) begin n_fail++; $display("FAIL glitch_wait_lock: got %0d exp 1", STATE); end
        tick();
        n_checks++; if (STATE !== 3'd2) begin n_fail++; $display("FAIL glitch_restart: got %0d exp 2", STATE); end
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_checks++; if (STATE !== 3'd2 || MSS_RESET_N !== 1'b0) begin n_fail++; $display("FAIL glitch_count[%0d]: got state %0d mss %b exp 2/0", k, STATE, MSS_RESET_N); end
        end
        tick();
        n_checks++; if (STATE !== 3'd3) begin n_fail++; $display("FAIL glitch_delay: got %0d exp 3", STATE); end
        wait_state(3'd4, 20, found);
        n_checks++; if (!found || MSS_RESET_N !== 1'b1) begin n_fail++; $display("FAIL relock_wait_mss: got state %0d mss %b exp 4/1", STATE, MSS_RESET_N); end
        MSS_READY = 1'b1;
        wait_state(3'd5, 10, found);
        n_checks++; if (!found || INIT_DONE !== 1'b1) begin n_fail++; $display("FAIL relock_run: got state %0d init %b exp 5/1", STATE, INIT_DONE); end
    endtask

    task automatic test_soft_reset_run_and_timeout();
        bit found;
        SOFT_RESET_REQ = 1'b1;
        tick();
        SOFT_RESET_REQ = 1'b0; MSS_READY = 1'b0;
        n_checks++; if (STATE !== 3'd0) begin n_fail++; $display("FAIL soft_run_state: got %0d exp 0", STATE); end
        n_checks++; if ({MSS_RESET_N, FABRIC_RESET_N, INIT_DONE} !== 3'b000) begin n_fail++; $display("FAIL soft_run_outs: got %b exp 000", {MSS_RESET_N, FABRIC_RESET_N, INIT_DONE}); end
        tick();
        n_checks++; if (STATE !== 3'd1) begin n_fail++; $display("FAIL soft_run_resume: got %0d exp 1", STATE); end
        wait_state(3'd4, 60, found);
        n_checks++; if (!found) begin n_fail++; $display("FAIL to_reach_wait_mss: got %0d exp 4", STATE); end
        for (int k = 1; k <= 99; k++) begin
            tick();
            n_checks++; if (STATE !== 3'd4) begin n_fail++; $display("FAIL to_waiting[%0d]: got %0d exp 4", k, STATE); end
        end
        tick();
        n_checks++; if (STATE !== 3'd6) begin n_fail++; $display("FAIL to_state: got %0d exp 6", STATE); end
        n_checks++; if (TIMEOUT_ERR !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b exp 1", TIMEOUT_ERR); end
        n_checks++; if ({MSS_RESET_N, FABRIC_RESET_N, INIT_DONE} !== 3'b100) begin n_fail++; $display("FAIL to_outs: got %b exp 100", {MSS_RESET_N, FABRIC_RESET_N, INIT_DONE}); end
        repeat (5) tick();
        n_checks++; if (STATE !== 3'd6 || TIMEOUT_ERR !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got state %0d terr %b exp 6/1", STATE, TIMEOUT_ERR); end
    endtask

    task automatic test_soft_reset_error_and_ready_wins();
        bit found;
        SOFT_RESET_REQ = 1'b1;
        tick();
        SOFT_RESET_REQ = 1'b0;
        n_checks++; if (STATE !== 3'd0) begin n_fail++; $display("FAIL soft_err_state: got %0d exp 0", STATE); end
        n_checks++; if (TIMEOUT_ERR !== 1'b0) begin n_fail++; $display("FAIL soft_err_clear: got %b exp 0", TIMEOUT_ERR); end
        n_checks++; if (MSS_RESET_N !== 1'b0 || FABRIC_RESET_N !== 1'b0) begin n_fail++; $display("FAIL soft_err_resets: got %b%b exp 00", MSS_RESET_N, FABRIC_RESET_N); end
        wait_state(3'd4, 60, found);
        n_checks++; if (!found) begin n_fail++; $display("FAIL rw_reach_wait_mss: got %0d exp 4", STATE); end
        // ready_s rises exactly when the timeout counter reaches its terminal count.
        repeat (97) tick();
        MSS_READY = 1'b1;
        tick(); tick();
        n_checks++; if (STATE !== 3'd4) begin n_fail++; $display("FAIL rw_pre: got %0d exp 4", STATE); end
        tick();
        n_checks++; if (STATE !== 3'd5) begin n_fail++; $display("FAIL rw_state: got %0d exp 5", STATE); end
        n_checks++; if (TIMEOUT_ERR !== 1'b0 || INIT_DONE !== 1'b1) begin n_fail++; $display("FAIL rw_outs: got terr %b init %b exp 0/1", TIMEOUT_ERR, INIT_DONE); end
    endtask

    task automatic test_async_reset_wait_mss();
        bit found;
        SOFT_RESET_REQ = 1'b1;
        tick();
        SOFT_RESET_REQ = 1'b0; MSS_READY = 1'b0;
        wait_state(3'd4, 60, found);
        n_checks++; if (!found) begin n_fail++; $display("FAIL ar_reach_wait_mss: got %0d exp 4", STATE); end
        repeat (3) tick();
        @(posedge CLK);
        #7 RESETN = 1'b0;
        #1;
        n_checks++; if (STATE !== 3'd0) begin n_fail++; $display("FAIL ar_state: got %0d exp 0", STATE); end
        n_checks++; if ({MSS_RESET_N, FABRIC_RESET_N, INIT_DONE, TIMEOUT_ERR} !== 4'b0000) begin n_fail++; $display("FAIL ar_outs: got %b exp 0000", {MSS_RESET_N, FABRIC_RESET_N, INIT_DONE, TIMEOUT_ERR}); end
        #1 RESETN = 1'b1;
        tick();
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_checks++; if (STATE !== 3'd0 || MSS_RESET_N !== 1'b0 || FABRIC_RESET_N !== 1'b0) begin n_fail++; $display("FAIL ar_hold[%0d]: got state %0d mss %b fab %b exp 0/0/0", k, STATE, MSS_RESET_N, FABRIC_RESET_N); end
        end
        tick();
        n_checks++; if (STATE !== 3'd1) begin n_fail++; $display("FAIL ar_release: got %0d exp 1", STATE); end
        wait_state(3'd4, 60, found);
        n_checks++; if (!found) begin n_fail++; $display("FAIL ar_resequence: got %0d exp 4", STATE); end
        MSS_READY = 1'b1;
        wait_state(3'd5, 10, found);
        n_checks++; if (!found || FABRIC_RESET_N !== 1'b1) begin n_fail++; $display("FAIL ar_run: got state %0d fab %b exp 5/1", STATE, FABRIC_RESET_N); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RESETN = 1'b0; CCC_LOCK = 1'b1; MSS_READY = 1'b0; SOFT_RESET_REQ = 1'b0;
        test_reset();
        test_sequence();
        test_lock_loss_and_glitch();
        test_soft_reset_run_and_timeout();
        test_soft_reset_error_and_ready_wins();
        test_async_reset_wait_mss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/osc_reset_sequencer.md
Name: osc_reset_sequencer

Overview:
- Consumes the 50 MHz fabric RC-oscillator clock (RCOSC_25_50MHZ_O2F) directly downstream of the oscillator wrapper.
- Sequences reset release for the MSS and the fabric after power-up, in three steps:
  - waits for a stable CCC lock;
  - releases the MSS and waits for its ready indication;
  - releases the fabric.
- Re-runs the sequence on lock loss or a soft-reset request, and reports a timeout.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive cycles CCC_LOCK must be high before MSS release.
- MSS_RELEASE_DELAY, 256: cycles between lock-stable and MSS_RESET_N deassertion.
- MSS_READY_TIMEOUT, 65535: max cycles to wait for MSS_READY after MSS release.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers (min 2).

Ports:
- CLK  in  1  fabric oscillator clock, 50 MHz (RCOSC_25_50MHZ_O2F)
- RESETN  in  1  asynchronous active-low reset (power-on / DEVRST)
- CCC_LOCK  in  1  CCC lock, asynchronous to CLK
- MSS_READY  in  1  MSS init-complete, asynchronous to CLK
- SOFT_RESET_REQ  in  1  single-cycle synchronous request to re-sequence
- MSS_RESET_N  out  1  MSS reset, active-low
- FABRIC_RESET_N  out  1  fabric reset, active-low
- INIT_DONE  out  1  high in RUN only
- TIMEOUT_ERR  out  1  sticky MSS_READY timeout flag
- STATE  out  3  current state encoding, for debug

Behaviour:
- One clock, CLK. RESETN is asynchronous and active-low.
  - Asserts all flops immediately.
  - Deassertion is used internally only after a SYNC_STAGES-deep reset synchronizer; all state releases synchronously.
- Reset values:
  - MSS_RESET_N=0, FABRIC_RESET_N=0, INIT_DONE=0, TIMEOUT_ERR=0, STATE=RST_HOLD.
  - Synchronizer flops reset to 0.
- CCC_LOCK and MSS_READY each pass through a SYNC_STAGES flop chain (lock_s, ready_s); SYNC_STAGES cycles of latency.
- Counter cnt has width clog2 of the largest parameter + 1. It clears on every state entry and saturates (no wrap).
- State encoding: RST_HOLD=0, WAIT_LOCK=1, LOCK_STABLE=2, MSS_DELAY=3, WAIT_MSS=4, RUN=5, ERROR=6.
- RST_HOLD:
  - Both resets asserted.
  - Goes to WAIT_LOCK on the first cycle after synchronized reset release.
- WAIT_LOCK: stays until lock_s=1, then goes to LOCK_STABLE.
- LOCK_STABLE:
  - cnt increments while lock_s=1; lock_s=0 returns to WAIT_LOCK.
  - cnt==LOCK_STABLE_CYCLES-1 with lock_s=1 goes to MSS_DELAY.
- MSS_DELAY: cnt==MSS_RELEASE_DELAY-1 goes to WAIT_MSS.
- WAIT_MSS:
  - MSS_RESET_N=1 (registered; rises the cycle STATE shows WAIT_MSS).
  - ready_s=1 goes to RUN.
  - cnt==MSS_READY_TIMEOUT-1 without ready goes to ERROR and sets TIMEOUT_ERR.
- RUN: FABRIC_RESET_N=1 and INIT_DONE=1 (registered, visible with STATE=RUN).
- ERROR:
  - MSS_RESET_N=1, FABRIC_RESET_N=0, TIMEOUT_ERR=1.
  - Exits only via SOFT_RESET_REQ (to RST_HOLD) or RESETN.
- Lock loss: lock_s=0 in MSS_DELAY, WAIT_MSS or RUN goes to WAIT_LOCK.
  - Both resets reassert on the next edge; INIT_DONE drops on the same edge.
- SOFT_RESET_REQ:
  - In any state except RST_HOLD it goes to RST_HOLD; both resets reassert on the next edge.
  - Takes priority over lock loss and timeout in the same cycle.
  - Clears TIMEOUT_ERR.
- RESETN low mid-sequence: all outputs return to reset values asynchronously.
- Simultaneous ready_s=1 and timeout terminal count: ready wins (goes to RUN).
- All outputs come straight from flops; no combinational path from any input to any output.

Decomposition:
- Shared package osc_rst_pkg holds:
  - the state typedef and encodings above;
  - a clog2 function;
  - the default timing constants.
- One sub-module, osc_rst_sync: a parameterized SYNC_STAGES flop chain with asynchronous active-low reset.
  - Instantiated three times: CCC_LOCK, MSS_READY, and the reset-release synchronizer (D tied to 1).

Test Plan:
- RESETN low 10 cycles, then high; CCC_LOCK high from cycle 0; MSS_READY high 20 cycles after MSS release -> with LOCK_STABLE_CYCLES=16 and MSS_RELEASE_DELAY=8:
  - MSS_RESET_N rises about 27 cycles after reset release;
  - FABRIC_RESET_N and INIT_DONE rise SYNC_STAGES+1 cycles after MSS_READY;
  - STATE steps 0,1,2,3,4,5.
- CCC_LOCK glitches low for 1 cycle at LOCK_STABLE count 10 -> STATE returns to 1, the count restarts, and MSS_RESET_N stays 0 throughout.
- CCC_LOCK drops while in RUN -> both resets 0 and INIT_DONE=0 within SYNC_STAGES+1 cycles; the full sequence repeats after lock returns.
- MSS_READY held 0 with MSS_READY_TIMEOUT=100 -> ERROR after 100 cycles in WAIT_MSS, with TIMEOUT_ERR=1, FABRIC_RESET_N=0, MSS_RESET_N=1.
- SOFT_RESET_REQ pulse in ERROR and again in RUN -> STATE=0 next cycle, TIMEOUT_ERR cleared, resets asserted, and the sequence completes again.
- RESETN pulsed low for 2 ns, asynchronous to CLK, during WAIT_MSS -> all outputs at reset values immediately, and no output toggles before the synchronized release.
